// File: rtl/pov_spi_receiver.sv
// pov_spi_receiver
//   SPI slave (mode 0, MSB first) that receives a 74-bit point-of-view packet
//   {px[14:0], py[14:0], fx[10:0], fy[10:0], vx[10:0], vy[10:0]} and holds it
//   pending until the next frame boundary, so the view never changes mid-frame.
//
// Ports
//   clk, reset          : system clock, async active-high reset
//   i_sclk/i_mosi/i_ss_n: SPI pins, asynchronous to clk
//   i_frame_start       : one-clk pulse at start of vblank
//   o_px..o_vy          : applied POV vector (registered)
//   o_pending           : complete packet waiting for a frame boundary
//   o_updated           : one-clk pulse when o_px..o_vy change
module pov_spi_receiver #(
    parameter int          POV_BITS = 74,
    parameter logic [14:0] RESET_PX = 15'h0300,
    parameter logic [14:0] RESET_PY = 15'h0300,
    parameter logic [10:0] RESET_FX = 11'h200,
    parameter logic [10:0] RESET_FY = 11'h000,
    parameter logic [10:0] RESET_VX = 11'h000,
    parameter logic [10:0] RESET_VY = 11'h700
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_sclk,
    input  logic        i_mosi,
    input  logic        i_ss_n,
    input  logic        i_frame_start,
    output logic [14:0] o_px,
    output logic [14:0] o_py,
    output logic [10:0] o_fx,
    output logic [10:0] o_fy,
    output logic [10:0] o_vx,
    output logic [10:0] o_vy,
    output logic        o_pending,
    output logic        o_updated
);

    localparam int CW = $clog2(POV_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(POV_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(POV_BITS + 1);   // overrun marker

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [POV_BITS-1:0] POV_RESET =
        {RESET_PX, RESET_PY, RESET_FX, RESET_FY, RESET_VX, RESET_VY};

    // ---------------- synchronisers ----------------
    logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic mosi_s1_q, mosi_s2_q;
    logic ss_s1_q, ss_s2_q, ss_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            ss_s1_q     <= 1'b1;
            ss_s2_q     <= 1'b1;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_s1_q   <= i_sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            mosi_s1_q   <= i_mosi;
            mosi_s2_q   <= mosi_s1_q;
            ss_s1_q     <= i_ss_n;
            ss_s2_q     <= ss_s1_q;
            ss_prev_q   <= ss_s2_q;
        end
    end

    logic sclk_rise, ss_fall, ss_rise;
    assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
    assign ss_fall   = ~ss_s2_q & ss_prev_q;
    assign ss_rise   = ss_s2_q & ~ss_prev_q;

    // ---------------- receive FSM ----------------
    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [POV_BITS-1:0] shift_q, shift_d;
    logic                done_q, done_d;     // exact-length packet just closed
    logic [POV_BITS-1:0] pend_q, pend_d;
    logic [POV_BITS-1:0] pov_q, pov_d;
    logic                pending_q, pending_d;
    logic                updated_q, updated_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ss_fall) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (ss_rise) begin
                    state_d = S_IDLE;
                    done_d  = (cnt_q == CNT_FULL);
                end else if (sclk_rise) begin
                    shift_d = {shift_q[POV_BITS-2:0], mosi_s2_q};
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Apply path. The shift register is frozen in IDLE, so it can be copied to
    // the pending buffer one cycle after the ss_n rise. If a packet completes
    // on the same edge as frame_start, the old pending contents are applied
    // and the new packet stays pending.
    always_comb begin
        pend_d    = pend_q;
        pov_d     = pov_q;
        pending_d = pending_q;
        updated_d = 1'b0;
        if (i_frame_start && pending_q) begin
            pov_d     = pend_q;
            pending_d = 1'b0;
            updated_d = 1'b1;
        end
        if (done_q) begin
            pend_d    = shift_q;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            pend_q    <= '0;
            pov_q     <= POV_RESET;
            pending_q <= 1'b0;
            updated_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
            pov_q     <= pov_d;
            pending_q <= pending_d;
            updated_q <= updated_d;
        end
    end

    assign o_px      = pov_q[73:59];
    assign o_py      = pov_q[58:44];
    assign o_fx      = pov_q[43:33];
    assign o_fy      = pov_q[32:22];
    assign o_vx      = pov_q[21:11];
    assign o_vy      = pov_q[10:0];
    assign o_pending = pending_q;
    assign o_updated = updated_q;

endmodule

// File: doc/pov_spi_receiver.md
Name: pov_spi_receiver

Overview:
- SPI slave that loads a new point-of-view (POV) vector from the external `pov_sclk`/`pov_mosi`/`pov_ss_n` pins.
- Sits directly downstream of the top-level `ui_in[2:0]` pins and upstream of the raycaster/row-render core, which consumes its POV outputs.
- Double-buffered: a complete packet is held pending and only applied at a frame boundary, so the view never changes mid-frame.

Parameters:
- POV_BITS, 74, packet length: px15 + py15 + fx11 + fy11 + vx11 + vy11.
- RESET_PX, 15'h0300, player X at reset (Q6.9, value 1.5).
- RESET_PY, 15'h0300, player Y at reset (Q6.9, value 1.5).
- RESET_FX, 11'h200, facing X at reset (Q2.9, value 1.0).
- RESET_FY, 11'h000, facing Y at reset (value 0).
- RESET_VX, 11'h000, viewplane X at reset (value 0).
- RESET_VY, 11'h700, viewplane Y at reset (Q2.9, value -0.5).

Ports:
- clk, input, 1, system/pixel clock.
- reset, input, 1, asynchronous, active-high reset.
- i_sclk, input, 1, SPI clock, asynchronous to clk, mode 0.
- i_mosi, input, 1, SPI data, MSB first.
- i_ss_n, input, 1, SPI select, active low.
- i_frame_start, input, 1, one-clk pulse at start of vblank.
- o_px, output, 15, applied player X.
- o_py, output, 15, applied player Y.
- o_fx, output, 11, applied facing X.
- o_fy, output, 11, applied facing Y.
- o_vx, output, 11, applied viewplane X.
- o_vy, output, 11, applied viewplane Y.
- o_pending, output, 1, a complete packet is waiting for the next frame boundary.
- o_updated, output, 1, one-clk pulse when the outputs change.

Behaviour:
- Reset (async, active-high, all flops):
  - o_* take their RESET_* values; o_pending=0; o_updated=0.
  - Shift register and bit counter are cleared.
  - Synchronisers reset to: sclk=0, mosi=0, ss_n=1.
- Synchronisation:
  - i_sclk, i_mosi and i_ss_n each pass through a 2-FF synchroniser, plus one history flop on sclk and on ss_n.
  - An sclk rising edge is detected as sync=1 && prev=0; mosi is sampled from its synchroniser on that same cycle.
  - Requirement: each SPI clock phase and the ss_n setup/hold must be at least 3 clk periods.
- Receive state machine (states IDLE, SHIFT):
  - IDLE -> SHIFT on synchronised ss_n falling edge; bit counter cleared to 0.
  - In SHIFT, each sclk rising edge shifts mosi into the LSB of the 74-bit shift register. The counter increments and saturates at POV_BITS+1, which marks overrun.
  - SHIFT -> IDLE on synchronised ss_n rising edge:
    - If counter == POV_BITS: the shift register is copied to the pending buffer and o_pending is set the next cycle.
    - Any other count (short or overrun): the packet is discarded silently and pending is untouched.
  - sclk edges while in IDLE are ignored.
- Packet field order, first bit received = MSB:
  - px[14:0], py[14:0], fx[10:0], fy[10:0], vx[10:0], vy[10:0].
  - Equivalently, shift-register bit 73 is px[14] and bit 0 is vy[0].
- Apply:
  - If i_frame_start=1 and o_pending=1: the pending buffer is copied to o_* on that clk edge, o_pending clears, and o_updated pulses high for exactly that one following cycle.
  - i_frame_start with o_pending=0 leaves o_* unchanged and does not pulse o_updated.
- Boundary cases:
  - A second complete packet while pending overwrites the pending buffer; only the latest is applied.
  - Packet completion and i_frame_start in the same cycle: the old pending contents (if any) are applied, then the new packet becomes pending for the next frame. No packet is lost if none was pending.
  - ss_n falling mid-SHIFT without a preceding rise cannot occur; an ss_n glitch shorter than the synchroniser window is undefined.
  - Reset mid-transfer aborts the transfer; the next packet must begin with a fresh ss_n falling edge.
- Latency:
  - ss_n rise to o_pending=1: 4 clk (2 sync + 1 edge detect + 1 register).
  - i_frame_start to new o_*: 1 clk.
- Outputs are fully registered with no combinational path from the inputs.

Test Plan:
1. Reset: assert reset for 3 clk, release -> o_px=0x300, o_py=0x300, o_fx=0x200, o_fy=0, o_vx=0, o_vy=0x700, o_pending=0.
2. Valid packet: send px=0x1234, py=0x0456, fx=0x1FF, fy=0x001, vx=0x7FF, vy=0x400 at sclk=clk/8 -> o_pending=1 and o_* unchanged. Then pulse i_frame_start -> o_* match the sent values, o_updated high for 1 clk, o_pending=0.
3. Short (73 bits) and long (75 bits) packets, each followed by i_frame_start -> o_* retain their previous values, o_pending=0, no o_updated pulse.
4. Two back-to-back valid packets (px=0x0001 then px=0x0002) before i_frame_start -> after the pulse o_px=0x0002.
5. Align the ss_n rise so o_pending would set on the same cycle as i_frame_start, with an earlier packet px=0x0011 pending and the new packet px=0x0022 -> o_px=0x0011 immediately, o_pending stays 1, next i_frame_start -> o_px=0x0022.
6. Assert reset after 40 bits of a packet, release, send a full valid packet -> only the second packet is received and applied correctly.
